// File: rtl/audio_min_max_sched.sv
// Two-requester window min/max engine sharing one RAM read port and one accumulator.
// Requests are served round-robin; each result is returned with a one-cycle done pulse.
module audio_min_max_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start0,
  input  logic [ADDR_W-1:0] base0,
  input  logic [LEN_W-1:0]  len0,
  input  logic              start1,
  input  logic [ADDR_W-1:0] base1,
  input  logic [LEN_W-1:0]  len1,
  output logic              busy0,
  output logic              busy1,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              d,
  output logic              d_id,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic              out_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic              pend0_q, pend1_q;
  logic [ADDR_W-1:0] base0_q, base1_q;
  logic [LEN_W-1:0]  len0_q, len1_q;
  logic              last_id_q, last_id_d;
  logic              id_q, id_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              rd_vld_q;
  logic signed [DATA_W-1:0] acc_max_q, acc_max_d, acc_min_q, acc_min_d;
  logic signed [DATA_W-1:0] rdata_s;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              d_q, d_d, d_id_q, d_id_d, out_err_q, out_err_d;
  logic [DATA_W-1:0] out_max_q, out_max_d, out_min_q, out_min_d;

  logic              any_pend_c, gnt_id_c, clr0_c, clr1_c;
  logic [ADDR_W-1:0] gnt_base_c;
  logic [LEN_W-1:0]  gnt_len_c;

  assign rdata_s  = $signed(mem_rdata);
  assign busy0    = pend0_q;
  assign busy1    = pend1_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign d        = d_q;
  assign d_id     = d_id_q;
  assign out_max  = out_max_q;
  assign out_min  = out_min_q;
  assign out_err  = out_err_q;

  // Round-robin grant: with both pending, the channel not served last wins.
  always_comb begin
    any_pend_c = pend0_q | pend1_q;
    gnt_id_c   = pend1_q;
    if (pend0_q && pend1_q) gnt_id_c = ~last_id_q;
    gnt_base_c = gnt_id_c ? base1_q : base0_q;
    gnt_len_c  = gnt_id_c ? len1_q : len0_q;
  end

  // Request capture; a start while already pending is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      base0_q <= '0;
      base1_q <= '0;
      len0_q  <= '0;
      len1_q  <= '0;
    end else begin
      if (!pend0_q && start0) begin
        pend0_q <= 1'b1;
        base0_q <= base0;
        len0_q  <= len0;
      end else if (clr0_c) begin
        pend0_q <= 1'b0;
      end
      if (!pend1_q && start1) begin
        pend1_q <= 1'b1;
        base1_q <= base1;
        len1_q  <= len1;
      end else if (clr1_c) begin
        pend1_q <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_pend_c) state_d = (gnt_len_c == '0) ? S_DONE : S_READ;
      S_READ:  if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and datapath next values; accumulation runs the cycle after each read.
  always_comb begin
    cnt_d      = cnt_q;
    id_d       = id_q;
    first_d    = first_q;
    acc_max_d  = acc_max_q;
    acc_min_d  = acc_min_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    d_d        = 1'b0;
    d_id_d     = d_id_q;
    out_max_d  = out_max_q;
    out_min_d  = out_min_q;
    out_err_d  = out_err_q;
    last_id_d  = last_id_q;
    clr0_c     = 1'b0;
    clr1_c     = 1'b0;

    if (rd_vld_q) begin
      if (first_q) begin
        acc_max_d = rdata_s;
        acc_min_d = rdata_s;
        first_d   = 1'b0;
      end else begin
        if (rdata_s > acc_max_q) acc_max_d = rdata_s;
        if (rdata_s < acc_min_q) acc_min_d = rdata_s;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (any_pend_c) begin
          id_d       = gnt_id_c;
          cnt_d      = gnt_len_c;
          first_d    = 1'b1;
          mem_addr_d = gnt_base_c;
          if (gnt_len_c == '0) begin
            d_d       = 1'b1;
            d_id_d    = gnt_id_c;
            out_err_d = 1'b1;
            out_max_d = '0;
            out_min_d = '0;
          end else begin
            mem_rd_d = 1'b1;
          end
        end
      end
      S_READ: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q != LEN_W'(1)) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        d_d       = 1'b1;
        d_id_d    = id_q;
        out_max_d = acc_max_d;
        out_min_d = acc_min_d;
        out_err_d = 1'b0;
      end
      S_DONE: begin
        last_id_d = id_q;
        clr0_c    = ~id_q;
        clr1_c    = id_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id_q  <= 1'b1;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      acc_max_q  <= '0;
      acc_min_q  <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      d_q        <= 1'b0;
      d_id_q     <= 1'b0;
      out_max_q  <= '0;
      out_min_q  <= '0;
      out_err_q  <= 1'b0;
    end else begin
      last_id_q  <= last_id_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      rd_vld_q   <= mem_rd_q;
      acc_max_q  <= acc_max_d;
      acc_min_q  <= acc_min_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      d_q        <= d_d;
      d_id_q     <= d_id_d;
      out_max_q  <= out_max_d;
      out_min_q  <= out_min_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_audio_min_max_sched.sv
// Directed bench for audio_min_max_sched with a result scoreboard and a read-address queue.
module tb_audio_min_max_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [9:0]  base0, base1;
  logic [10:0] len0, len1;
  logic        busy0, busy1, mem_rd, d, d_id, out_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] out_max, out_min;

  typedef struct {
    logic        id;
    logic [31:0] mx;
    logic [31:0] mn;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  aq[$];
  exp_t        mon_e;
  logic [31:0] mem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 1;
  int          t;
  int          n;
  bit          chk_addr = 1'b1;

  audio_min_max_sched dut (
    .clk(clk), .reset(reset),
    .start0(start0), .base0(base0), .len0(len0),
    .start1(start1), .base1(base1), .len1(len1),
    .busy0(busy0), .busy1(busy1),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .d(d), .d_id(d_id), .out_max(out_max), .out_min(out_min), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // cyc at a falling edge names the cycle that ends at the next rising edge
  always @(posedge clk) cyc++;

  // 1-cycle-latency sample RAM model
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_req(input logic id, input logic [31:0] mx, input logic [31:0] mn,
                          input logic err, input int exp_cyc, input int base, input int len);
    exp_t e;
    e.id = id; e.mx = mx; e.mn = mn; e.err = err; e.exp_cyc = exp_cyc;
    sb.push_back(e);
    for (int i = 0; i < len; i++) aq.push_back(10'((base + i) % 1024));
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy0 || busy1) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 64'(k < max_cyc), 64'd1);
    chk("addr_queue_empty", 64'(aq.size()), 64'd0);
    @(negedge clk);
  endtask

  // Result and read-address monitor
  always @(negedge clk) begin
    if (!reset && d) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_d: got d_id=%0d with no result expected", d_id);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("d_id", 64'(d_id), 64'(mon_e.id));
        chk("out_max", 64'(out_max), 64'(mon_e.mx));
        chk("out_min", 64'(out_min), 64'(mon_e.mn));
        chk("out_err", 64'(out_err), 64'(mon_e.err));
        if (mon_e.exp_cyc >= 0) chk("d_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
      end
    end
    if (!reset && mem_rd && chk_addr) begin
      n_vec++;
      assert (aq.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_read: got addr %0d with none expected", mem_addr);
      end
      if (aq.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(aq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'd196608;     mem[1] = 32'd458752;   mem[2] = 32'd0;
    mem[3] = -32'sd65536;    mem[4] = -32'sd1769472; mem[5] = 32'd327680;
    mem[1022] = -32'sd5;     mem[1023] = 32'd7;
    mem[10] = 32'h8000_0000; mem[11] = 32'h7FFF_FFFF;
    mem[20] = 32'd5; mem[21] = 32'd5; mem[22] = 32'd5;
    mem_rdata = '0;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    base0 = '0; base1 = '0; len0 = '0; len1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_out_max", 64'(out_max), 64'd0);
    chk("rst_out_min", 64'(out_min), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous requests after reset: channel 0 first
    base0 = 10'd0; len0 = 11'd3; base1 = 10'd3; len1 = 11'd2;
    start0 = 1'b1; start1 = 1'b1; t = cyc;
    push_req(1'b0, 32'd458752, 32'd0, 1'b0, t + 6, 0, 3);
    push_req(1'b1, -32'sd65536, -32'sd1769472, 1'b0, t + 11, 3, 2);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    wait_idle(60);

    // Single request with cycle-exact read strobe and busy timing
    base0 = 10'd0; len0 = 11'd6; start0 = 1'b1; t = cyc;
    push_req(1'b0, 32'd458752, -32'sd1769472, 1'b0, t + 9, 0, 6);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      chk("single_mem_rd", 64'(mem_rd), 64'((i >= 2) && (i <= 7)));
      chk("single_busy0", 64'(busy0), 64'(i <= 9));
    end
    wait_idle(20);

    // Second simultaneous pair: channel 1 first after channel 0 was served last
    base0 = 10'd0; len0 = 11'd3; base1 = 10'd3; len1 = 11'd2;
    start0 = 1'b1; start1 = 1'b1; t = cyc;
    push_req(1'b1, -32'sd65536, -32'sd1769472, 1'b0, t + 5, 3, 2);
    push_req(1'b0, 32'd458752, 32'd0, 1'b0, t + 11, 0, 3);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    wait_idle(60);

    // Window wrapping past the top of the address space
    base1 = 10'd1022; len1 = 11'd4; start1 = 1'b1; t = cyc;
    push_req(1'b1, 32'd458752, -32'sd5, 1'b0, t + 7, 1022, 4);
    @(negedge clk);
    start1 = 1'b0;
    wait_idle(40);

    // Zero-length window
    base0 = 10'd7; len0 = 11'd0; start0 = 1'b1; t = cyc;
    push_req(1'b0, 32'd0, 32'd0, 1'b1, t + 2, 0, 0);
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(20);

    // Restart while busy is ignored
    base0 = 10'd0; len0 = 11'd6; start0 = 1'b1; t = cyc;
    push_req(1'b0, 32'd458752, -32'sd1769472, 1'b0, t + 9, 0, 6);
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    base0 = 10'd4; len0 = 11'd1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("restart_busy0", 64'(busy0), 64'd1);
    wait_idle(40);
    repeat (6) @(negedge clk);

    // Start arriving on the cycle of its own done pulse is ignored
    base1 = 10'd5; len1 = 11'd1; start1 = 1'b1;
    push_req(1'b1, 32'd327680, 32'd327680, 1'b0, -1, 5, 1);
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (d !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("own_d_seen", 64'(d), 64'd1);
    base1 = 10'd0; len1 = 11'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("own_d_busy1", 64'(busy1), 64'd0);
    wait_idle(20);

    // Signed extremes and equal samples
    base0 = 10'd9; len0 = 11'd4; start0 = 1'b1;
    push_req(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, -1, 9, 4);
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(40);
    base1 = 10'd20; len1 = 11'd3; start1 = 1'b1;
    push_req(1'b1, 32'd5, 32'd5, 1'b0, -1, 20, 3);
    @(negedge clk);
    start1 = 1'b0;
    wait_idle(40);

    // Reset in the middle of a read burst
    chk_addr = 1'b0;
    base0 = 10'd0; len0 = 11'd6; start0 = 1'b1; t = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_mem_rd", 64'(mem_rd), 64'd0);
    chk("midrst_busy0", 64'(busy0), 64'd0);
    chk("midrst_d", 64'(d), 64'd0);
    chk("midrst_out_max", 64'(out_max), 64'd0);
    chk("midrst_out_min", 64'(out_min), 64'd0);
    chk("midrst_out_err", 64'(out_err), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_busy0", 64'(busy0), 64'd0);
    chk("postrst_out_max", 64'(out_max), 64'd0);
    aq.delete();
    chk_addr = 1'b1;

    // Fresh request after reset
    base0 = 10'd4; len0 = 11'd1; start0 = 1'b1; t = cyc;
    push_req(1'b0, -32'sd1769472, -32'sd1769472, 1'b0, t + 4, 4, 1);
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
